// File: rtl/interp_timing_sched_if.sv
// ---------------------------------------------------------------------------
// interp_timing_sched_if
// Bundle of the scheduler's control inputs and its outputs toward the
// polyphase interpolator.
//   master : drives en_i, iq_raw_val_i, adj_i, adj_val_i; observes outputs
//   slave  : the scheduler itself (consumes inputs, drives outputs)
// Signals:
//   en_i          scheduler enable
//   iq_raw_val_i  raw IQ sample strobe
//   adj_i         signed timing correction, raw-sample units Q.MUW
//   adj_val_i     adj_i qualifier
//   phase_int_o   integer accumulator part at strobe (0..OSF-1)
//   mu_o          fractional accumulator part at strobe
//   phase_val_o   delay-line shift enable
//   sym_valid_o   one-cycle symbol strobe
//   adj_sat_o     one-cycle pulse: captured correction was clipped
//   state_o       0=IDLE 1=FILL 2=TRACK
// ---------------------------------------------------------------------------
interface interp_timing_sched_if #(
  parameter int MUW  = 27,
  parameter int ADJW = 28
);
  logic                   en_i;
  logic                   iq_raw_val_i;
  logic signed [ADJW-1:0] adj_i;
  logic                   adj_val_i;
  logic [4:0]             phase_int_o;
  logic [MUW-1:0]         mu_o;
  logic                   phase_val_o;
  logic                   sym_valid_o;
  logic                   adj_sat_o;
  logic [1:0]             state_o;

  modport master (
    output en_i, iq_raw_val_i, adj_i, adj_val_i,
    input  phase_int_o, mu_o, phase_val_o, sym_valid_o, adj_sat_o, state_o
  );

  modport slave (
    input  en_i, iq_raw_val_i, adj_i, adj_val_i,
    output phase_int_o, mu_o, phase_val_o, sym_valid_o, adj_sat_o, state_o
  );
endinterface

// File: rtl/interp_timing_sched.sv
// ---------------------------------------------------------------------------
// interp_timing_sched
// Symbol-timing scheduler for a polyphase interpolator. A fractional timing
// accumulator advances by one raw sample per iq_raw_val_i, plus a one-shot
// loop-filter correction. Each wrap past OSF raw samples issues a symbol
// strobe carrying the integer branch index and fractional mu. Tracking only
// starts once the interpolator delay line (OSF*TAPS_PPH samples) is full.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active low
//   bus  interp_timing_sched_if.slave (enable, sample strobe, correction in;
//        phase_int/mu/phase_val/sym_valid/adj_sat/state out)
// ---------------------------------------------------------------------------
module interp_timing_sched #(
  parameter int OSF      = 20,
  parameter int TAPS_PPH = 5,
  parameter int MUW      = 27,
  parameter int ADJW     = 28,
  parameter int MAX_ADJ  = 2**26
) (
  input  logic                        clk,
  input  logic                        rst,
  interp_timing_sched_if.slave        bus
);

  localparam int DEPTH = OSF * TAPS_PPH;
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam int ACCW  = 5 + MUW;
  localparam int NXTW  = ACCW + 1;
  localparam int PW    = MUW + 1;

  localparam logic signed [NXTW-1:0] ONE     = NXTW'(longint'(1) << MUW);
  localparam logic signed [NXTW-1:0] LIMIT   = NXTW'(longint'(OSF) << MUW);
  localparam logic signed [ADJW-1:0] MAX_POS = ADJW'(MAX_ADJ);
  localparam logic signed [ADJW-1:0] MAX_NEG = -MAX_POS;
  localparam logic signed [PW-1:0]   PEND_POS = PW'(MAX_ADJ);
  localparam logic signed [PW-1:0]   PEND_NEG = -PEND_POS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ACCW-1:0]        acc_q, acc_d;
  logic [CNTW-1:0]        fill_cnt_q, fill_cnt_d;
  logic signed [PW-1:0]   pend_q, pend_d;
  logic [4:0]             phase_int_q, phase_int_d;
  logic [MUW-1:0]         mu_q, mu_d;
  logic                   phase_val_q, phase_val_d;
  logic                   sym_valid_q, sym_valid_d;
  logic                   adj_sat_q, adj_sat_d;

  logic signed [NXTW-1:0] nxt;
  logic                   wrap;
  logic [ACCW-1:0]        acc_next;
  logic                   adj_hi, adj_lo;
  logic signed [PW-1:0]   adj_clip;

  // Next accumulator value for one raw sample. The pending correction is
  // strictly smaller than one sample, so the sum is positive and can cross
  // the OSF boundary at most once.
  always_comb begin
    nxt      = $signed({1'b0, acc_q}) + ONE + NXTW'(pend_q);
    wrap     = (nxt >= LIMIT);
    acc_next = wrap ? ACCW'(nxt - LIMIT) : ACCW'(nxt);
  end

  // Clip the incoming correction to +/-MAX_ADJ before it is stored.
  always_comb begin
    adj_hi   = (bus.adj_i > MAX_POS);
    adj_lo   = (bus.adj_i < MAX_NEG);
    adj_clip = adj_hi ? PEND_POS : (adj_lo ? PEND_NEG : PW'(bus.adj_i));
  end

  // Next-state and output logic. Dropping en_i aborts to IDLE from anywhere
  // and discards accumulator, fill count and pending correction.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fill_cnt_d  = fill_cnt_q;
    pend_d      = pend_q;
    phase_int_d = phase_int_q;
    mu_d        = mu_q;
    sym_valid_d = 1'b0;
    adj_sat_d   = 1'b0;

    if (!bus.en_i) begin
      state_d    = IDLE;
      acc_d      = '0;
      fill_cnt_d = '0;
      pend_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = FILL;
          acc_d      = '0;
          fill_cnt_d = '0;
        end
        FILL: begin
          // The sample that completes the delay line is not accumulated.
          if (bus.iq_raw_val_i) begin
            if (fill_cnt_q == CNTW'(DEPTH - 1)) begin
              state_d    = TRACK;
              acc_d      = '0;
              fill_cnt_d = '0;
            end else begin
              fill_cnt_d = fill_cnt_q + CNTW'(1);
            end
          end
        end
        TRACK: begin
          if (bus.iq_raw_val_i) begin
            acc_d  = acc_next;
            pend_d = '0;
            if (wrap) begin
              sym_valid_d = 1'b1;
              phase_int_d = acc_next[ACCW-1:MUW];
              mu_d        = acc_next[MUW-1:0];
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // A correction arriving with a consuming sample is stored for the
      // next sample; the old value was already used above.
      if (state_q != IDLE && bus.adj_val_i) begin
        pend_d    = adj_clip;
        adj_sat_d = adj_hi | adj_lo;
      end
    end

    phase_val_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      fill_cnt_q  <= '0;
      pend_q      <= '0;
      phase_int_q <= '0;
      mu_q        <= '0;
      phase_val_q <= 1'b0;
      sym_valid_q <= 1'b0;
      adj_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_cnt_q  <= fill_cnt_d;
      pend_q      <= pend_d;
      phase_int_q <= phase_int_d;
      mu_q        <= mu_d;
      phase_val_q <= phase_val_d;
      sym_valid_q <= sym_valid_d;
      adj_sat_q   <= adj_sat_d;
    end
  end

  assign bus.phase_int_o = phase_int_q;
  assign bus.mu_o        = mu_q;
  assign bus.phase_val_o = phase_val_q;
  assign bus.sym_valid_o = sym_valid_q;
  assign bus.adj_sat_o   = adj_sat_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_interp_timing_sched.sv
// ---------------------------------------------------------------------------
// tb_interp_timing_sched
// Self-checking bench for interp_timing_sched. Directed scenarios for fill,
// nominal timing, +/- half-sample corrections, saturation, abort and reset,
// followed by randomized traffic against a sample-level reference model that
// tracks timing as a plain integer count of 2**-MUW sample units.
// ---------------------------------------------------------------------------
module tb_interp_timing_sched;

  localparam int     MUW   = 27;
  localparam int     ADJW  = 28;
  localparam int     DEPTH = 100;
  localparam longint ONE   = longint'(1) << MUW;
  localparam longint LIMIT = 20 * ONE;
  localparam longint MAXA  = longint'(1) << 26;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  interp_timing_sched_if #(.MUW(MUW), .ADJW(ADJW)) bus ();

  interp_timing_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int     m_state;
  int     m_fill;
  longint m_acc;
  longint m_pend;
  longint exp_phase;
  longint exp_mu;
  bit     exp_sym;
  bit     exp_sat;
  bit     exp_pv;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock of the scheduler described at sample level.
  task automatic modelStep(input bit r, input bit e, input bit iq, input longint adj, input bit av);
    int     old;
    longint np;
    bit     clip;
    exp_sym = 1'b0;
    exp_sat = 1'b0;
    if (!r) begin
      m_state = 0; m_fill = 0; m_acc = 0; m_pend = 0;
      exp_phase = 0; exp_mu = 0; exp_pv = 1'b0;
      return;
    end
    if (!e) begin
      m_state = 0; m_fill = 0; m_acc = 0; m_pend = 0;
      exp_pv = 1'b0;
      return;
    end
    old = m_state;
    np  = m_pend;
    if (old == 0) begin
      m_state = 1;
      m_fill  = 0;
    end else if (old == 1) begin
      if (iq) begin
        m_fill++;
        if (m_fill == DEPTH) begin
          m_state = 2; m_acc = 0; m_fill = 0;
        end
      end
    end else begin
      if (iq) begin
        m_acc = m_acc + ONE + m_pend;
        np = 0;
        if (m_acc >= LIMIT) begin
          m_acc     = m_acc - LIMIT;
          exp_sym   = 1'b1;
          exp_phase = m_acc / ONE;
          exp_mu    = m_acc % ONE;
        end
      end
    end
    if (old != 0 && av) begin
      clip    = (adj > MAXA) || (adj < -MAXA);
      np      = clip ? ((adj > 0) ? MAXA : -MAXA) : adj;
      exp_sat = clip;
    end
    m_pend = np;
    exp_pv = (m_state != 0);
  endtask

  // Drive one cycle of inputs, advance the model, compare after the edge.
  task automatic applyStimulus(input bit r, input bit e, input bit iq,
                               input logic signed [ADJW-1:0] adj, input bit av);
    @(negedge clk);
    rst              = r;
    bus.en_i         = e;
    bus.iq_raw_val_i = iq;
    bus.adj_i        = adj;
    bus.adj_val_i    = av;
    modelStep(r, e, iq, longint'(adj), av);
    @(posedge clk);
    #1;
    checkOutput("sym_valid", bus.sym_valid_o, exp_sym);
    checkOutput("state", bus.state_o, m_state);
    checkOutput("phase_val", bus.phase_val_o, exp_pv);
    checkOutput("adj_sat", bus.adj_sat_o, exp_sat);
    checkOutput("phase_int", bus.phase_int_o, exp_phase);
    checkOutput("mu", bus.mu_o, exp_mu);
  endtask

  // From IDLE: enable, then stream samples until TRACK (bounded).
  task automatic fillUp(input string tag);
    int n = 0;
    applyStimulus(1, 1, 0, '0, 0);
    checkOutput({tag, "_pv"}, bus.phase_val_o, 1);
    while (bus.state_o != 2'd2 && n < 2 * DEPTH) begin
      applyStimulus(1, 1, 1, '0, 0);
      n++;
    end
    checkOutput({tag, "_count"}, n, DEPTH);
  endtask

  // Stream samples until a symbol strobe appears (bounded); check count.
  task automatic runUntilSym(input string tag, input int expn);
    int n    = 0;
    bit seen = 1'b0;
    while (!seen && n < 60) begin
      applyStimulus(1, 1, 1, '0, 0);
      n++;
      if (bus.sym_valid_o) seen = 1'b1;
    end
    checkOutput(tag, n, expn);
  endtask

  function automatic logic signed [ADJW-1:0] pickAdj();
    logic signed [ADJW-1:0] v;
    case ($urandom_range(0, 3))
      0: v = ADJW'($urandom);
      1: v = ADJW'(longint'($urandom_range(0, 2 * 67108864)) - MAXA);
      2: v = ($urandom_range(0, 1) != 0) ? ADJW'(MAXA) : ADJW'(-MAXA);
      default: v = ($urandom_range(0, 1) != 0) ? ADJW'(MAXA + 1) : ADJW'(-MAXA - 1);
    endcase
    return v;
  endfunction

  initial begin
    logic signed [ADJW-1:0] a;
    bus.en_i         = 1'b0;
    bus.iq_raw_val_i = 1'b0;
    bus.adj_i        = '0;
    bus.adj_val_i    = 1'b0;

    // reset wins even with enable and strobes active
    repeat (3) applyStimulus(0, 1, 1, '0, 1);
    checkOutput("rst_state", bus.state_o, 0);
    checkOutput("rst_pv", bus.phase_val_o, 0);
    checkOutput("rst_sym", bus.sym_valid_o, 0);
    checkOutput("rst_mu", bus.mu_o, 0);
    applyStimulus(1, 0, 0, '0, 0);

    // fill then nominal timing
    fillUp("t1_fill");
    runUntilSym("t2_first", 20);
    checkOutput("t2_phase", bus.phase_int_o, 0);
    checkOutput("t2_mu", bus.mu_o, 0);
    runUntilSym("t2_period", 20);

    // abort mid-TRACK with a sample that would otherwise count
    repeat (5) applyStimulus(1, 1, 1, '0, 0);
    applyStimulus(1, 0, 1, '0, 0);
    checkOutput("t6_abort_state", bus.state_o, 0);
    checkOutput("t6_abort_pv", bus.phase_val_o, 0);
    checkOutput("t6_abort_sym", bus.sym_valid_o, 0);

    // +half sample correction
    fillUp("t3_fill");
    applyStimulus(1, 1, 0, ADJW'(MAXA), 1);
    checkOutput("t3_sat", bus.adj_sat_o, 0);
    runUntilSym("t3_first", 20);
    checkOutput("t3_phase", bus.phase_int_o, 0);
    checkOutput("t3_mu", bus.mu_o, MAXA);
    runUntilSym("t3_period", 20);

    // -half sample correction
    applyStimulus(1, 0, 0, '0, 0);
    fillUp("t4_fill");
    applyStimulus(1, 1, 0, ADJW'(-MAXA), 1);
    checkOutput("t4_sat", bus.adj_sat_o, 0);
    runUntilSym("t4_first", 21);
    checkOutput("t4_phase", bus.phase_int_o, 0);
    checkOutput("t4_mu", bus.mu_o, MAXA);

    // saturated correction
    applyStimulus(1, 0, 0, '0, 0);
    fillUp("t5_fill");
    applyStimulus(1, 1, 0, ADJW'((longint'(1) << 27) - 1), 1);
    checkOutput("t5_sat", bus.adj_sat_o, 1);
    runUntilSym("t5_first", 20);
    checkOutput("t5_mu", bus.mu_o, MAXA);

    // reset in the middle of FILL, then a full refill
    applyStimulus(1, 0, 0, '0, 0);
    applyStimulus(1, 1, 0, '0, 0);
    repeat (30) applyStimulus(1, 1, 1, '0, 0);
    applyStimulus(0, 1, 1, '0, 0);
    checkOutput("t6_rst_state", bus.state_o, 0);
    checkOutput("t6_rst_pv", bus.phase_val_o, 0);
    checkOutput("t6_rst_phase", bus.phase_int_o, 0);
    checkOutput("t6_rst_mu", bus.mu_o, 0);
    fillUp("t6_refill");

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      a = pickAdj();
      applyStimulus(($urandom_range(0, 999) != 0),
                    ($urandom_range(0, 799) != 0),
                    ($urandom_range(0, 9) < 7),
                    a,
                    ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
